// File: rtl/coeff_bank.sv
// Coefficient register bank streamed to a MAC over a valid/ready handshake.
// Optional shadow bank with commit is enabled by defining COEFF_BANK_SHADOW_EN.
module coeff_bank #(
    parameter int unsigned COEFF_W   = 32,
    parameter int unsigned NUM_COEFF = 11,
    parameter int unsigned IDX_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               start,
`ifdef COEFF_BANK_SHADOW_EN
    input  logic               commit,
`endif
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_o,
    output logic [IDX_W-1:0]   coeff_idx,
    output logic               coeff_valid,
    output logic               coeff_last,
    output logic               busy,
    output logic               wr_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic [IDX_W-1:0]   rd_idx;
    logic [COEFF_W-1:0] rd_data;
    logic               wr_ok;
    logic [COEFF_W-1:0] bank [NUM_COEFF];

`ifdef COEFF_BANK_SHADOW_EN
    logic [COEFF_W-1:0] shadow [NUM_COEFF];
    logic               commit_pend;
    logic               apply;

    assign apply = (commit || commit_pend) && (state == IDLE) && !start;
`endif

    assign wr_ok       = wr_en && (wr_idx <= LAST_IDX);
    assign coeff_valid = (state == RUN);
    assign busy        = (state == RUN);
    assign coeff_last  = coeff_valid && (coeff_idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rd_idx    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (coeff_ready) begin
                    if (coeff_idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        load   = 1'b1;
                        rd_idx = coeff_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux only ever selects a populated entry, so no out-of-range access exists.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_COEFF; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = bank[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            coeff_o   <= '0;
            coeff_idx <= '0;
            wr_err    <= 1'b0;
            for (int unsigned i = 0; i < NUM_COEFF; i++) begin
                bank[i] <= '0;
            end
`ifdef COEFF_BANK_SHADOW_EN
            for (int unsigned i = 0; i < NUM_COEFF; i++) begin
                shadow[i] <= '0;
            end
            commit_pend <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            wr_err <= wr_en && !wr_ok;
            if (load) begin
                coeff_o   <= rd_data;
                coeff_idx <= rd_idx;
            end
`ifdef COEFF_BANK_SHADOW_EN
            commit_pend <= (commit || commit_pend) && !apply;
            for (int unsigned i = 0; i < NUM_COEFF; i++) begin
                if (wr_ok && (wr_idx == IDX_W'(i))) begin
                    shadow[i] <= wr_data;
                end
                if (apply) begin
                    bank[i] <= shadow[i];
                end
            end
`else
            // A write racing the read of the same entry: rd_data already holds the old value.
            for (int unsigned i = 0; i < NUM_COEFF; i++) begin
                if (wr_ok && (wr_idx == IDX_W'(i))) begin
                    bank[i] <= wr_data;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_coeff_bank.sv
// Scoreboard bench for coeff_bank: sweeps are predicted from an array model of the bank(s).
// Define COEFF_BANK_SHADOW_EN to exercise the shadow/commit build.
module tb_coeff_bank;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 11;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          commit = 1'b0;
    logic          coeff_ready = 1'b0;
    logic [W-1:0]  coeff_o;
    logic [IW-1:0] coeff_idx;
    logic          coeff_valid;
    logic          coeff_last;
    logic          busy;
    logic          wr_err;

    always #5 clk = ~clk;

    coeff_bank #(
        .COEFF_W  (W),
        .NUM_COEFF(N),
        .IDX_W    (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .start      (start),
`ifdef COEFF_BANK_SHADOW_EN
        .commit     (commit),
`endif
        .coeff_ready(coeff_ready),
        .coeff_o    (coeff_o),
        .coeff_idx  (coeff_idx),
        .coeff_valid(coeff_valid),
        .coeff_last (coeff_last),
        .busy       (busy),
        .wr_err     (wr_err)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [IW-1:0] i;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    logic [W-1:0] m_act[N];
    logic [W-1:0] m_sh[N];
    bit           m_pend = 1'b0;
    int           hs_cnt = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_o = '0;
    logic [IW-1:0] prev_idx = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable at the falling edge; a handshake there completes at the next rise.
    always @(negedge clk) begin
        if (!rst) begin
            check("last_flag", 32'(coeff_last), 32'(coeff_valid && (coeff_idx == IW'(N - 1))));
            if (prev_stall) begin
                check("hold_valid", 32'(coeff_valid), 32'(1));
                check("hold_o", coeff_o, prev_o);
                check("hold_idx", 32'(coeff_idx), 32'(prev_idx));
            end
            if (coeff_valid && coeff_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got idx %0d data 0x%0h expected none", coeff_idx, coeff_o);
                end else begin
                    e = q.pop_front();
                    check("coeff_o", coeff_o, e.d);
                    check("coeff_idx", 32'(coeff_idx), 32'(e.i));
                end
            end
        end
        prev_stall = !rst && coeff_valid && !coeff_ready;
        prev_o     = coeff_o;
        prev_idx   = coeff_idx;
    end

    task automatic wr_entry(input int idx, input logic [W-1:0] val);
        wr_en   = 1'b1;
        wr_idx  = IW'(idx);
        wr_data = val;
        tick();
        wr_en = 1'b0;
        if (idx >= int'(N)) begin
            check("wr_err_pulse", 32'(wr_err), 32'(1));
            tick();
            check("wr_err_clear", 32'(wr_err), 32'(0));
        end else begin
            check("wr_err_quiet", 32'(wr_err), 32'(0));
`ifdef COEFF_BANK_SHADOW_EN
            m_sh[idx] = val;
`else
            m_act[idx] = val;
`endif
        end
    endtask

    task automatic commit_idle();
`ifdef COEFF_BANK_SHADOW_EN
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < int'(N); i++) m_act[i] = m_sh[i];
`endif
    endtask

    // mode: 0 ready always, 1 stall 3 cycles at idx 4, 2 random ready
    task automatic run_sweep(input int mode, input int spur_at, input bit start_on_last,
                             input int rst_at, input int wr_at, input logic [W-1:0] wr_val,
                             input bit do_commit, input bit chk_timing);
        int           cyc;
        int           stall_left;
        bit           wr_done;
        bit           aborted;
        logic [W-1:0] last_val;
        wr_done    = 1'b0;
        aborted    = 1'b0;
        stall_left = 3;
        start      = 1'b0;
        tick();
        if (m_pend) begin
            for (int i = 0; i < int'(N); i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end
        hs_cnt = 0;
        for (int i = 0; i < int'(N); i++) q.push_back('{m_act[i], IW'(i)});
        last_val = m_act[N-1];
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (busy && cyc < 300 && !aborted) begin
            case (mode)
                0: coeff_ready = 1'b1;
                1: begin
                    if (coeff_idx == IW'(4) && stall_left > 0) begin
                        coeff_ready = 1'b0;
                        stall_left--;
                    end else begin
                        coeff_ready = 1'b1;
                    end
                end
                default: coeff_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (spur_at >= 0 && int'(coeff_idx) == spur_at) start = 1'b1;
            if (start_on_last && coeff_last && coeff_ready) start = 1'b1;
            if (wr_at >= 0 && !wr_done && int'(coeff_idx) == wr_at) begin
                coeff_ready = 1'b1;
                wr_en       = 1'b1;
                wr_idx      = IW'(wr_at + 1);
                wr_data     = wr_val;
                wr_done     = 1'b1;
`ifdef COEFF_BANK_SHADOW_EN
                m_sh[wr_at+1] = wr_val;
`else
                m_act[wr_at+1] = wr_val;
`endif
            end else if (do_commit && wr_done && int'(coeff_idx) > wr_at) begin
                commit = 1'b1;
`ifdef COEFF_BANK_SHADOW_EN
                m_pend = 1'b1;
`endif
            end
            if (rst_at >= 0 && int'(coeff_idx) == rst_at) begin
                rst     = 1'b1;
                aborted = 1'b1;
            end
            tick();
            cyc++;
            start  = 1'b0;
            wr_en  = 1'b0;
            commit = 1'b0;
        end
        coeff_ready = 1'b0;
        if (aborted) begin
            rst = 1'b0;
            check("rst_valid", 32'(coeff_valid), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_o", coeff_o, 32'(0));
            check("rst_idx", 32'(coeff_idx), 32'(0));
            q.delete();
            for (int i = 0; i < int'(N); i++) begin
                m_act[i] = '0;
                m_sh[i]  = '0;
            end
            m_pend = 1'b0;
        end else if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: got busy after %0d cycles expected idle", cyc);
        end else begin
            check("hs_count", 32'(hs_cnt), 32'(N));
            check("queue_drained", 32'(q.size()), 32'(0));
            check("end_valid", 32'(coeff_valid), 32'(0));
            check("end_o_hold", coeff_o, last_val);
            if (chk_timing) check("sweep_cycles", 32'(cyc), 32'(N + 1));
            if (start_on_last) begin
                tick();
                check("late_start_busy", 32'(busy), 32'(0));
                check("late_start_valid", 32'(coeff_valid), 32'(0));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) begin
            m_act[i] = '0;
            m_sh[i]  = '0;
        end
        rst = 1'b1;
        start = 1'b1;
        wr_en = 1'b1;
        wr_idx = IW'(2);
        wr_data = 32'h1234;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        tick();
        check("reset_valid", 32'(coeff_valid), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_last", 32'(coeff_last), 32'(0));
        check("reset_idx", 32'(coeff_idx), 32'(0));
        check("reset_o", coeff_o, 32'(0));
        check("reset_wr_err", 32'(wr_err), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < int'(N); i++) wr_entry(i, W'(100 + i));
        commit_idle();
        run_sweep(0, -1, 1'b0, -1, -1, '0, 1'b0, 1'b1);
        run_sweep(1, -1, 1'b0, -1, -1, '0, 1'b0, 1'b0);

        wr_entry(11, 32'hDEAD);
        wr_entry(15, $urandom);
        commit_idle();
        run_sweep(0, -1, 1'b0, -1, -1, '0, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) wr_entry(int'($urandom_range(0, N - 1)), $urandom);
        commit_idle();
        run_sweep(2, 6, 1'b0, -1, -1, '0, 1'b0, 1'b0);
        run_sweep(2, -1, 1'b1, -1, -1, '0, 1'b0, 1'b0);

        run_sweep(2, -1, 1'b0, -1, 2, 32'h55, 1'b1, 1'b0);
        run_sweep(2, -1, 1'b0, -1, -1, '0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) wr_entry(int'($urandom_range(0, N - 1)), $urandom);
            run_sweep(2, -1, 1'b0, -1, -1, '0, 1'b0, 1'b0);
            commit_idle();
        end

        run_sweep(0, -1, 1'b0, 5, -1, '0, 1'b0, 1'b0);
        run_sweep(0, -1, 1'b0, -1, -1, '0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coeff_bank.md
COEFF_BANK -- requirements
Module: coeff_bank

Interface
REQ-001 Parameter COEFF_W, default 32, coefficient width in bits.
REQ-002 Parameter NUM_COEFF, default 11, number of coefficient entries (2..256).
REQ-003 Parameter IDX_W, default 4, index width; SHALL satisfy 2**IDX_W >= NUM_COEFF.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  coefficient write strobe.
REQ-007 wr_idx  in  IDX_W  write index.
REQ-008 wr_data  in  COEFF_W  write data.
REQ-009 start  in  1  one-cycle pulse; begins a sweep of all coefficients.
REQ-010 coeff_ready  in  1  downstream MAC accepts the current coefficient.
REQ-011 coeff_o  out  COEFF_W  streamed coefficient.
REQ-012 coeff_idx  out  IDX_W  index of coeff_o.
REQ-013 coeff_valid  out  1  coeff_o/coeff_idx valid.
REQ-014 coeff_last  out  1  coeff_o is entry NUM_COEFF-1.
REQ-015 busy  out  1  sweep in progress.
REQ-016 wr_err  out  1  one-cycle pulse: write rejected, wr_idx >= NUM_COEFF.

Function
REQ-017 Storage: NUM_COEFF registers of COEFF_W bits; no read of an out-of-range index ever occurs.
REQ-018 Write: wr_en with wr_idx < NUM_COEFF updates the entry at the next edge; wr_idx >= NUM_COEFF leaves storage unchanged and pulses wr_err the next cycle.
REQ-019 FSM states: IDLE, RUN. IDLE->RUN on start; RUN->IDLE on the handshake (coeff_valid & coeff_ready) with coeff_last=1.
REQ-020 In IDLE, start loads coeff_idx=0, coeff_o=entry 0, coeff_valid=1 at the next edge (latency 1 cycle).
REQ-021 In RUN, each handshake advances coeff_idx by 1 and registers the next entry in the same edge; back-to-back handshakes give one coefficient per cycle.
REQ-022 While coeff_valid=1 and coeff_ready=0, coeff_o, coeff_idx and coeff_last SHALL hold stable.
REQ-023 coeff_last = coeff_valid & (coeff_idx == NUM_COEFF-1).
REQ-024 On the final handshake, coeff_valid and busy deassert at the next edge; coeff_o holds its last value.
REQ-025 busy = 1 in RUN, 0 in IDLE.
REQ-026 start while busy is ignored (no restart, no error).
REQ-027 start on the same edge as the final handshake is ignored; a new start is accepted from the following cycle.
REQ-028 Write to entry k in the same cycle that entry k is registered onto coeff_o: coeff_o carries the old value; the new value is seen by later sweeps.
REQ-029 No wrap-around: coeff_idx never exceeds NUM_COEFF-1.

Reset
REQ-030 rst=1 at an edge: all entries 0, FSM IDLE, coeff_o=0, coeff_idx=0, coeff_valid=0, coeff_last=0, busy=0, wr_err=0.
REQ-031 rst overrides start, wr_en and any handshake in the same cycle; a sweep in progress is aborted, with no further coeff_valid.

Configuration
REQ-032 Macro COEFF_BANK_SHADOW_EN.
REQ-033 Defined: writes go to a shadow bank; input commit (1 bit) copies shadow to active bank at the next edge only in IDLE with no start that cycle; commit otherwise stays pending and applies at the first edge in IDLE without start; sweeps read the active bank only; reset clears both banks and the pending flag.
REQ-034 Not defined: no commit port, single bank; writes during RUN take effect immediately, subject to REQ-028.

Verification
REQ-035 Reset, write entries 0..10 = 100..110, start, coeff_ready=1 -> coeff_o 100..110 on 11 consecutive cycles, coeff_last only with 110, busy low one cycle after.
REQ-036 Sweep with coeff_ready low for 3 cycles at idx 4 -> coeff_o=104, idx=4 held stable 3 cycles, then sweep resumes at 105.
REQ-037 wr_en, wr_idx=11, wr_data=0xDEAD -> wr_err pulse one cycle, then a sweep shows all entries unchanged.
REQ-038 start pulsed at idx 6 of a sweep -> ignored; sweep completes at 10, exactly 11 handshakes total.
REQ-039 rst asserted at idx 5 -> coeff_valid=0, busy=0, all entries 0 next cycle; next sweep streams all zeros.
REQ-040 COEFF_BANK_SHADOW_EN: write entry 3=0x55 then commit during RUN -> current sweep shows old entry 3; next sweep shows 0x55.
